// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the memory port scheduler
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  localparam int DEF_TIMEOUT = 15;
  localparam int ABORT_DATA = 0;
endpackage

// File: rtl/mem_wd_timer.sv
// mem_wd_timer: watchdog counting unacknowledged request cycles, strobes on expiry
module mem_wd_timer
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic ack,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !ack && cnt != LIMIT) cnt <= cnt + 1'b1;
  assign expire = en & ~ack & (cnt == LIMIT);
endmodule

// File: rtl/mem_port_sched.sv
// mem_port_sched: shares one memory port between fetch and data, data first, with watchdog abort
module mem_port_sched
  import mips_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          timeout_err
);
  state_t state, nxt;
  logic if_pend, d_pend, fin, expire, grant;
  logic [DW-1:0] fin_data;
  // a request whose completion pulse is showing is already served
  assign if_pend = if_req & ~if_valid;
  assign d_pend = d_req & ~d_done;
  assign mem_req = state != IDLE;
  assign fin = mem_req & (mem_ack | expire);
  assign fin_data = mem_ack ? mem_rdata : DW'(ABORT_DATA);
  assign grant = nxt != IDLE && nxt != state;
  assign stall = if_pend | d_pend;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (d_pend ? BUSY_D : if_pend ? BUSY_IF : IDLE) :
          !fin ? state :
          state == BUSY_IF ? (d_pend ? BUSY_D : IDLE) :
          (if_pend ? BUSY_IF : IDLE);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_valid <= 1'b0;
      d_done <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_valid <= fin && state == BUSY_IF;
      d_done <= fin && state == BUSY_D;
      if (fin && state == BUSY_IF) if_rdata <= fin_data;
      if (fin && state == BUSY_D && !mem_we) d_rdata <= fin_data;
      if (expire) timeout_err <= 1'b1;
      if (grant) begin
        mem_addr <= nxt == BUSY_D ? d_addr : if_addr;
        mem_we <= nxt == BUSY_D && d_we;
        mem_wdata <= nxt == BUSY_D ? d_wdata : '0;
      end else if (nxt == IDLE) mem_we <= 1'b0;
    end
  mem_wd_timer #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .clr(grant),
    .en(mem_req),
    .ack(mem_ack),
    .expire(expire)
  );
endmodule
